// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronises and debounces the active-low board KEY buttons,
// then re-times them to game_tick so that even a press shorter than one tick is seen.
module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit LR_CANCEL       = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic                game_tick,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                move_right,
    output logic                jump,
    output logic                move_left,
    output logic                jump_press,
    output logic                any_input_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] pressed_sync;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] press_seen;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];
    logic                lr_both;

    // Reset to the released level so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ~sync2;

    // A new level must persist for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (pressed_sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= pressed_sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    // A rise coinciding with game_tick is folded into this tick's sample, not the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_d   <= '0;
            press_seen <= '0;
            key_held   <= '0;
            jump_press <= 1'b0;
        end else begin
            stable_d <= stable;
            if (game_tick) begin
                press_seen <= '0;
                key_held   <= stable | press_seen | rise;
                jump_press <= press_seen[1] | rise[1];
            end else begin
                press_seen <= press_seen | rise;
            end
        end
    end

    assign lr_both         = LR_CANCEL && key_held[0] && key_held[2];
    assign move_right      = key_held[0] & ~lr_both;
    assign move_left       = key_held[2] & ~lr_both;
    assign jump            = key_held[1];
    assign any_input_level = |key_held[2:0];

endmodule

// File: tb/tb_key_input_conditioner.sv
// Randomised and directed bench for key_input_conditioner, checked against a
// window-based reference model of debounce plus a timestamp model of tick capture.
module tb_key_input_conditioner;

    localparam int NUM_KEYS    = 4;
    localparam int DEB         = 8;
    localparam int CNT_W       = 4;
    localparam int TICK_PERIOD = 100;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_KEYS-1:0] KEY;
    logic                game_tick;
    logic [NUM_KEYS-1:0] key_held;
    logic                move_right, jump, move_left, jump_press, any_input_level;
    logic [NUM_KEYS-1:0] key_held_nc;
    logic                mr_nc, jump_nc, ml_nc, jp_nc, any_nc;

    int                  n_compared   = 0;
    int                  n_mismatched = 0;
    int                  cyc_no       = 0;
    int                  phase        = 0;
    bit                  tick_en      = 1'b1;
    bit                  tick_just_applied = 1'b0;
    logic [NUM_KEYS-1:0] cur_key;

    key_input_conditioner #(
        .NUM_KEYS(NUM_KEYS), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W), .LR_CANCEL(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .KEY(KEY), .game_tick(game_tick),
        .key_held(key_held), .move_right(move_right), .jump(jump), .move_left(move_left),
        .jump_press(jump_press), .any_input_level(any_input_level)
    );

    key_input_conditioner #(
        .NUM_KEYS(NUM_KEYS), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W), .LR_CANCEL(1'b0)
    ) u_dut_nc (
        .clk(clk), .rst(rst), .KEY(KEY), .game_tick(game_tick),
        .key_held(key_held_nc), .move_right(mr_nc), .jump(jump_nc), .move_left(ml_nc),
        .jump_press(jp_nc), .any_input_level(any_nc)
    );

    always #5 clk = ~clk;

    // Reference model: pins pass a two-edge delay line, a key's level flips once the last
    // DEB samples all disagree with it, and a tick reports "pressed now, or a press edge
    // landed in (previous tick, this tick]".
    logic [NUM_KEYS-1:0] pin_q [$];
    logic [DEB-1:0]      win [NUM_KEYS];
    int                  fill [NUM_KEYS];
    longint              rise_at [NUM_KEYS];
    logic [NUM_KEYS-1:0] m_stable, m_held;
    logic                m_jp;
    longint              edge_no = 0;
    longint              last_tick_edge = 0;

    always @(posedge clk or negedge rst) begin
        logic [NUM_KEYS-1:0] synced;
        logic                p;
        if (!rst) begin
            pin_q          = '{4'hF, 4'hF};
            m_stable       = '0;
            m_held         = '0;
            m_jp           = 1'b0;
            last_tick_edge = edge_no;
            for (int k = 0; k < NUM_KEYS; k++) begin
                win[k]     = '0;
                fill[k]    = 0;
                rise_at[k] = -1;
            end
        end else begin
            edge_no++;
            synced = pin_q.pop_front();
            pin_q.push_back(KEY);
            if (game_tick) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    m_held[k] = m_stable[k] | (rise_at[k] > last_tick_edge && rise_at[k] <= edge_no);
                end
                m_jp           = (rise_at[1] > last_tick_edge && rise_at[1] <= edge_no);
                last_tick_edge = edge_no;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                p      = ~synced[k];
                win[k] = {win[k][DEB-2:0], p};
                if (fill[k] < DEB) fill[k]++;
                if (fill[k] == DEB && win[k] == {DEB{~m_stable[k]}}) begin
                    m_stable[k] = p;
                    fill[k]     = 0;
                    if (p) rise_at[k] = edge_no + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_mr, exp_ml;
        exp_mr = m_held[0] & ~m_held[2];
        exp_ml = m_held[2] & ~m_held[0];
        checkOutput("key_held", 32'(key_held), 32'(m_held));
        checkOutput("ctrl", 32'({move_left, jump, move_right, jump_press, any_input_level}),
                    32'({exp_ml, m_held[1], exp_mr, m_jp, |m_held[2:0]}));
        checkOutput("ctrl_nocancel", 32'({key_held_nc, ml_nc, jump_nc, mr_nc, jp_nc, any_nc}),
                    32'({m_held, m_held[2], m_held[1], m_held[0], m_jp, |m_held[2:0]}));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput(tag, 32'({key_held, move_right, jump, move_left, jump_press, any_input_level,
                              key_held_nc, mr_nc, jump_nc, ml_nc, jp_nc, any_nc}), 32'h0);
    endtask

    // Each iteration ends on a falling edge, where outputs are sampled and inputs driven.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tick_just_applied = game_tick;
            cyc_no++;
            if (tick_just_applied || (cyc_no % 16) == 0) compare_model();
            phase     = (phase + 1) % TICK_PERIOD;
            game_tick = tick_en && (phase == TICK_PERIOD - 1);
            KEY       = cur_key;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_KEYS-1:0] keys, input int n);
        cur_key = keys;
        KEY     = keys;
        run_cycles(n);
    endtask

    task automatic wait_tick(input string tag);
        int got = 0;
        for (int c = 0; c < 2 * TICK_PERIOD && got == 0; c++) begin
            run_cycles(1);
            if (tick_just_applied) got = 1;
        end
        checkOutput({tag, "_tick_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_phase(input int target);
        for (int c = 0; c < TICK_PERIOD && phase != target; c++) run_cycles(1);
    endtask

    initial begin
        rst       = 1'b1;
        cur_key   = 4'h0;
        KEY       = 4'h0;
        game_tick = 1'b0;
        #1 rst = 1'b0;
        #1 check_all_zero("s1_reset");
        run_cycles(5);
        rst = 1'b1;
        run_cycles(10);
        checkOutput("s1_pre_tick", 32'(key_held), 32'h0);
        wait_tick("s1");
        checkOutput("s1_held_all", 32'(key_held), 32'hF);

        // Bouncy KEY[0]: only the final steady low may register.
        applyStimulus(4'hF, 2 * TICK_PERIOD + 20);
        checkOutput("s2_idle", 32'(key_held), 32'h0);
        applyStimulus(4'hE, 1);
        applyStimulus(4'hF, 3);
        applyStimulus(4'hE, 2);
        applyStimulus(4'hF, 3);
        applyStimulus(4'hE, 11);
        wait_tick("s2");
        checkOutput("s2_move_right", 32'(move_right), 32'd1);

        // Short jump press entirely between two ticks.
        applyStimulus(4'hF, 2 * TICK_PERIOD);
        wait_phase(40);
        applyStimulus(4'hD, 20);
        applyStimulus(4'hF, 1);
        wait_tick("s3a");
        checkOutput("s3_jump", 32'(jump), 32'd1);
        checkOutput("s3_jump_press", 32'(jump_press), 32'd1);
        wait_tick("s3b");
        checkOutput("s3_jump_after", 32'(jump), 32'd0);
        checkOutput("s3_jump_press_after", 32'(jump_press), 32'd0);

        // Jump held over five ticks: the press strobe covers only the first.
        applyStimulus(4'hD, 50);
        wait_tick("s4_first");
        checkOutput("s4_jump_first", 32'(jump), 32'd1);
        checkOutput("s4_jp_first", 32'(jump_press), 32'd1);
        for (int t = 0; t < 4; t++) begin
            wait_tick("s4_hold");
            checkOutput("s4_jump_hold", 32'(jump), 32'd1);
            checkOutput("s4_jp_hold", 32'(jump_press), 32'd0);
        end
        applyStimulus(4'hF, 1);
        wait_tick("s4_release");
        checkOutput("s4_jump_released", 32'(jump), 32'd0);

        // Left and right together.
        applyStimulus(4'hA, 30);
        wait_tick("s5");
        checkOutput("s5_lr_cancel", 32'({move_left, move_right, any_input_level}), 32'b001);
        checkOutput("s5_lr_nocancel", 32'({ml_nc, mr_nc, any_nc}), 32'b111);
        applyStimulus(4'hF, 2 * TICK_PERIOD);

        // Reset while held and with a release count in progress.
        applyStimulus(4'h0, 30);
        wait_tick("s6_held");
        checkOutput("s6_held_all", 32'(key_held), 32'hF);
        applyStimulus(4'hF, 4);
        rst = 1'b0;
        #1 check_all_zero("s6_reset");
        run_cycles(6);
        rst = 1'b1;
        wait_tick("s6_post1");
        checkOutput("s6_post1_held", 32'(key_held), 32'h0);
        wait_tick("s6_post2");
        checkOutput("s6_post2_held", 32'(key_held), 32'h0);

        // Random key patterns, stretches with the tick stuck low, and occasional resets.
        for (int it = 0; it < 120; it++) begin
            tick_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                #1 check_all_zero("rand_reset");
                run_cycles(int'($urandom_range(1, 4)));
                rst = 1'b1;
            end
            applyStimulus(4'($urandom), int'($urandom_range(1, 40)));
        end
        tick_en = 1'b1;
        applyStimulus(4'hF, 2 * TICK_PERIOD);
        compare_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
